// File: rtl/alu_bitwise_scheduler_pkg.sv
// rtl/alu_bitwise_scheduler_pkg.sv - shared constants, state encoding and arbitration helper
//
// Purpose: constants shared by the bitwise-unit scheduler and its arbiter.
//   - default datapath width, settle delay and settle counter width
//   - sched_state_t: IDLE=2'd0, SETTLE=2'd1, RESP=2'd2 (same encoding as the other ALU sequencers)
//   - rr_pick(): two-way round-robin choice used by the arbiter
package alu_bitwise_scheduler_pkg;

  localparam int SCHED_WIDTH         = 32;
  localparam int SCHED_SETTLE_CYCLES = 4;
  localparam int SCHED_CNT_W         = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } sched_state_t;

  // One-hot grant. On contention the requester that was not served last wins;
  // last=1 therefore hands a tie to requester 0.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] g;
    g = 2'b00;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/alu_bitwise_scheduler_rr_arb2.sv
// rtl/alu_bitwise_scheduler_rr_arb2.sv - two-input combinational round-robin arbiter
//
// Purpose: picks one of two pending requesters, alternating on contention.
// Ports:
//   req[1:0]    in   pending requests, bit X = requester X
//   last        in   index of the requester granted most recently
//   grant[1:0]  out  one-hot grant (all zero when nothing is requested)
module alu_bitwise_scheduler_rr_arb2
  import alu_bitwise_scheduler_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  assign grant = rr_pick(req, last);

endmodule

// File: rtl/alu_bitwise_scheduler.sv
// rtl/alu_bitwise_scheduler.sv - shares one 32-bit bitwise datapath between two requesters
//
// Purpose: round-robin arbitration, operand latching into the shared datapath,
//   a fixed settle delay for gate propagation, then a registered result
//   offered on a valid/ready response port.
// Build option: ALU_SCHED_ZERO_FLAG_EN adds res_zero (result == 0 flag).
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   r0_valid/r0_ready/r0_a/r0_b   requester 0 operation request and operands
//   r1_valid/r1_ready/r1_a/r1_b   requester 1 operation request and operands
//   dp_a, dp_b              registered operands into the shared datapath
//   dp_out                  combinational datapath result
//   res_valid/res_ready     result handshake
//   res_data, res_id        registered result and owning requester
//   busy                    high whenever the scheduler is not IDLE
//   res_zero                (ALU_SCHED_ZERO_FLAG_EN only) registered result-is-zero flag
module alu_bitwise_scheduler
  import alu_bitwise_scheduler_pkg::*;
#(
  parameter int WIDTH         = SCHED_WIDTH,
  parameter int SETTLE_CYCLES = SCHED_SETTLE_CYCLES,
  parameter int CNT_W         = SCHED_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  input  logic [WIDTH-1:0] dp_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             busy
`ifdef ALU_SCHED_ZERO_FLAG_EN
  ,
  output logic             res_zero
`endif
);

  // Loading SETTLE_CYCLES-1 and sampling at zero puts the result edge
  // exactly SETTLE_CYCLES edges after the accept edge.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  sched_state_t     state;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       grant;

  alu_bitwise_scheduler_rr_arb2 u_rr_arb2 (
    .req   ({r1_valid, r0_valid}),
    .last  (last_grant),
    .grant (grant)
  );

  assign r0_ready = (state == ST_IDLE) & grant[0];
  assign r1_ready = (state == ST_IDLE) & grant[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      dp_a       <= '0;
      dp_b       <= '0;
      res_data   <= '0;
      res_valid  <= 1'b0;
      res_id     <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
`ifdef ALU_SCHED_ZERO_FLAG_EN
      res_zero   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            dp_a       <= grant[1] ? r1_a : r0_a;
            dp_b       <= grant[1] ? r1_b : r0_b;
            res_id     <= grant[1];
            last_grant <= grant[1];
            cnt        <= CNT_LOAD;
            busy       <= 1'b1;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            res_data  <= dp_out;
`ifdef ALU_SCHED_ZERO_FLAG_EN
            res_zero  <= (dp_out == '0);
`endif
            res_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          // The handshake cycle only retires the result; arbitration resumes next cycle.
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bitwise_scheduler.sv
// tb/tb_alu_bitwise_scheduler.sv - scoreboard bench for alu_bitwise_scheduler (SETTLE_CYCLES 4 and 1)
module tb_alu_bitwise_scheduler;

  localparam int W = 32;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         reset;
  logic         r0_valid, r0_ready, r1_valid, r1_ready;
  logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
  logic [W-1:0] dp_a, dp_b, dp_out;
  logic         res_valid, res_ready, res_id, busy;
  logic [W-1:0] res_data;

  logic         s_r0_valid, s_r0_ready, s_r1_valid, s_r1_ready;
  logic [W-1:0] s_r0_a, s_r0_b, s_r1_a, s_r1_b;
  logic [W-1:0] s_dp_a, s_dp_b, s_dp_out;
  logic         s_res_valid, s_res_ready, s_res_id, s_busy;
  logic [W-1:0] s_res_data;
`ifdef ALU_SCHED_ZERO_FLAG_EN
  logic         res_zero, s_res_zero;
`endif

  // Bench model of the shared XOR_32 datapath.
  assign dp_out   = dp_a ^ dp_b;
  assign s_dp_out = s_dp_a ^ s_dp_b;

  alu_bitwise_scheduler #(.WIDTH(W), .SETTLE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .dp_a(dp_a), .dp_b(dp_b), .dp_out(dp_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy)
`ifdef ALU_SCHED_ZERO_FLAG_EN
    , .res_zero(res_zero)
`endif
  );

  alu_bitwise_scheduler #(.WIDTH(W), .SETTLE_CYCLES(1), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset),
    .r0_valid(s_r0_valid), .r0_ready(s_r0_ready), .r0_a(s_r0_a), .r0_b(s_r0_b),
    .r1_valid(s_r1_valid), .r1_ready(s_r1_ready), .r1_a(s_r1_a), .r1_b(s_r1_b),
    .dp_a(s_dp_a), .dp_b(s_dp_b), .dp_out(s_dp_out),
    .res_valid(s_res_valid), .res_ready(s_res_ready), .res_data(s_res_data),
    .res_id(s_res_id), .busy(s_busy)
`ifdef ALU_SCHED_ZERO_FLAG_EN
    , .res_zero(s_res_zero)
`endif
  );

  int   passed = 0;
  int   total  = 0;
  exp_t sb[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Waits for a ready on the selected instance; got = granted index, 2 = both, -1 = timeout.
  task automatic wait_grant(input bit d1, input int budget, output int got, output int acc_edge);
    logic rdy0, rdy1;
    got = -1;
    acc_edge = -1;
    #1;
    for (int i = 0; i < budget && got < 0; i++) begin
      rdy0 = d1 ? s_r0_ready : r0_ready;
      rdy1 = d1 ? s_r1_ready : r1_ready;
      if (rdy0 && rdy1) got = 2;
      else if (rdy0) got = 0;
      else if (rdy1) got = 1;
      else tick();
    end
    if (got >= 0) acc_edge = cyc + 1;
  endtask

  task automatic wait_result(input bit d1, input int budget, output bit ok, output int res_edge);
    ok = 1'b0;
    #1;
    for (int i = 0; i < budget && !ok; i++) begin
      if (d1 ? s_res_valid : res_valid) ok = 1'b1;
      else tick();
    end
    res_edge = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid: got %b want 0", res_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if ({dp_a, dp_b} !== 64'h0) $display("FAIL rst_dp: got %h %h want 0 0", dp_a, dp_b); else passed++;
    total++; if (res_data !== 32'h0) $display("FAIL rst_res_data: got %h want 0", res_data); else passed++;
    total++; if (res_id !== 1'b0) $display("FAIL rst_res_id: got %b want 0", res_id); else passed++;
    total++; if ({r0_ready, r1_ready} !== 2'b00) $display("FAIL rst_ready: got %b want 00", {r0_ready, r1_ready}); else passed++;
    total++; if ({s_res_valid, s_busy} !== 2'b00) $display("FAIL rst_s_state: got %b want 00", {s_res_valid, s_busy}); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    int got, acc, re;
    bit ok;
    exp_t e;
    r0_a = 32'hFFFF0000;
    r0_b = 32'h0F0F0F0F;
    r0_valid = 1'b1;
    res_ready = 1'b1;
    sb.push_back('{1'b0, 32'hF0F00F0F});
    wait_grant(0, 10, got, acc);
    total++; if (got !== 0) $display("FAIL t1_grant: got %0d want 0", got); else passed++;
    tick();
    r0_valid = 1'b0;
    total++; if (r0_ready !== 1'b0) $display("FAIL t1_ready_pulse: got %b want 0", r0_ready); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL t1_busy: got %b want 1", busy); else passed++;
    total++; if ({dp_a, dp_b} !== {32'hFFFF0000, 32'h0F0F0F0F}) $display("FAIL t1_dp: got %h %h want ffff0000 0f0f0f0f", dp_a, dp_b); else passed++;
    wait_result(0, 20, ok, re);
    total++; if (ok !== 1'b1) $display("FAIL t1_result_timeout: got %b want 1", ok); else passed++;
    total++; if (re - acc !== 4) $display("FAIL t1_latency: got %0d want 4", re - acc); else passed++;
    e = sb.pop_front();
    total++; if (res_data !== e.data) $display("FAIL t1_data: got %h want %h", res_data, e.data); else passed++;
    total++; if (res_id !== e.id) $display("FAIL t1_id: got %b want %b", res_id, e.id); else passed++;
    tick();
    total++; if ({res_valid, busy} !== 2'b00) $display("FAIL t1_retire: got %b want 00", {res_valid, busy}); else passed++;
  endtask

  task automatic test_alternate();
    int got, acc, re, prev_acc, exp_id;
    bit ok, model_last;
    exp_t e;
    apply_reset();
    model_last = 1'b1;
    prev_acc = -1;
    r0_a = $urandom; r0_b = $urandom; r1_a = $urandom; r1_b = $urandom;
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_id = model_last ? 0 : 1;
      sb.push_back('{exp_id[0], (exp_id == 1) ? (r1_a ^ r1_b) : (r0_a ^ r0_b)});
      wait_grant(0, 20, got, acc);
      total++; if (got !== exp_id) $display("FAIL t2_grant%0d: got %0d want %0d", k, got, exp_id); else passed++;
      if (prev_acc >= 0) begin
        total++; if (acc - prev_acc !== 6) $display("FAIL t2_interval%0d: got %0d want 6", k, acc - prev_acc); else passed++;
      end
      model_last = exp_id[0];
      prev_acc = acc;
      tick();
      if (exp_id == 1) begin r1_a = $urandom; r1_b = $urandom; end
      else begin r0_a = $urandom; r0_b = $urandom; end
      wait_result(0, 20, ok, re);
      e = sb.pop_front();
      total++; if ({ok, res_id, res_data} !== {1'b1, e.id, e.data}) $display("FAIL t2_result%0d: got ok=%b id=%b data=%h want ok=1 id=%b data=%h", k, ok, res_id, res_data, e.id, e.data); else passed++;
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    int got, acc, re;
    bit ok;
    exp_t e;
    apply_reset();
    r0_a = 32'hA5A5_1234; r0_b = 32'h0000_FFFF;
    r1_a = 32'h1111_2222; r1_b = 32'h3333_4444;
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    res_ready = 1'b0;
    sb.push_back('{1'b0, 32'hA5A5_EDCB});
    wait_grant(0, 10, got, acc);
    total++; if (got !== 0) $display("FAIL t3_grant: got %0d want 0", got); else passed++;
    tick();
    r0_valid = 1'b0;
    wait_result(0, 20, ok, re);
    total++; if (ok !== 1'b1) $display("FAIL t3_result_timeout: got %b want 1", ok); else passed++;
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({res_valid, res_id, res_data, r0_ready, r1_ready, busy} !== {1'b1, e.id, e.data, 1'b0, 1'b0, 1'b1})
        $display("FAIL t3_hold%0d: got v=%b id=%b data=%h rdy=%b%b busy=%b want v=1 id=%b data=%h rdy=00 busy=1",
                 i, res_valid, res_id, res_data, r0_ready, r1_ready, busy, e.id, e.data);
      else passed++;
      tick();
    end
    res_ready = 1'b1;
    tick();
    total++; if (res_valid !== 1'b0) $display("FAIL t3_release: got %b want 0", res_valid); else passed++;
    total++; if ({r1_ready, r0_ready} !== 2'b10) $display("FAIL t3_next_grant: got %b want 10", {r1_ready, r0_ready}); else passed++;
    tick();
    r1_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int got, acc, re;
    bit ok;
    exp_t e;
    apply_reset();
    r0_a = 32'hDEAD_BEEF; r0_b = 32'h0;
    r0_valid = 1'b1;
    r1_valid = 1'b0;
    res_ready = 1'b1;
    wait_grant(0, 10, got, acc);
    total++; if (got !== 0) $display("FAIL t4_grant_pre: got %0d want 0", got); else passed++;
    tick();
    r0_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    total++; if ({busy, res_valid} !== 2'b00) $display("FAIL t4_abort: got busy=%b valid=%b want 0 0", busy, res_valid); else passed++;
    total++; if (dp_a !== 32'h0) $display("FAIL t4_dp_a: got %h want 0", dp_a); else passed++;
    reset = 1'b0;
    r0_a = 32'h0F0F_0000; r0_b = 32'h00FF_00FF;
    r1_a = 32'h7777_7777; r1_b = 32'h1;
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    sb.push_back('{1'b0, 32'h0FF0_00FF});
    wait_grant(0, 10, got, acc);
    total++; if (got !== 0) $display("FAIL t4_first_grant: got %0d want 0", got); else passed++;
    tick();
    r0_valid = 1'b0;
    wait_result(0, 20, ok, re);
    e = sb.pop_front();
    total++; if ({ok, res_id, res_data} !== {1'b1, e.id, e.data}) $display("FAIL t4_result: got ok=%b id=%b data=%h want ok=1 id=%b data=%h", ok, res_id, res_data, e.id, e.data); else passed++;
    total++; if (re - acc !== 4) $display("FAIL t4_latency: got %0d want 4", re - acc); else passed++;
  endtask

  task automatic test_zero();
    int got, acc, re;
    bit ok;
    exp_t e;
    apply_reset();
    r1_valid = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      r0_a = (k == 0) ? 32'h12345678 : 32'h1;
      r0_b = (k == 0) ? 32'h12345678 : 32'h0;
      r0_valid = 1'b1;
      sb.push_back('{1'b0, (k == 0) ? 32'h0 : 32'h1});
      wait_grant(0, 10, got, acc);
      total++; if (got !== 0) $display("FAIL t5_grant%0d: got %0d want 0", k, got); else passed++;
      tick();
      r0_valid = 1'b0;
      wait_result(0, 20, ok, re);
      e = sb.pop_front();
      total++; if ({ok, res_data} !== {1'b1, e.data}) $display("FAIL t5_data%0d: got ok=%b data=%h want ok=1 data=%h", k, ok, res_data, e.data); else passed++;
`ifdef ALU_SCHED_ZERO_FLAG_EN
      total++; if (res_zero !== (k == 0)) $display("FAIL t5_zero%0d: got %b want %b", k, res_zero, (k == 0)); else passed++;
`endif
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int got, acc, re, prev_acc;
    bit ok;
    exp_t e;
    s_r1_valid = 1'b0;
    s_res_ready = 1'b1;
    s_r0_a = $urandom; s_r0_b = $urandom;
    s_r0_valid = 1'b1;
    prev_acc = -1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{1'b0, s_r0_a ^ s_r0_b});
      wait_grant(1, 10, got, acc);
      total++; if (got !== 0) $display("FAIL t6_grant%0d: got %0d want 0", k, got); else passed++;
      if (prev_acc >= 0) begin
        total++; if (acc - prev_acc !== 3) $display("FAIL t6_interval%0d: got %0d want 3", k, acc - prev_acc); else passed++;
      end
      prev_acc = acc;
      tick();
      s_r0_a = $urandom; s_r0_b = $urandom;
      wait_result(1, 10, ok, re);
      total++; if (re - acc !== 1) $display("FAIL t6_latency%0d: got %0d want 1", k, re - acc); else passed++;
      e = sb.pop_front();
      total++; if ({ok, s_res_id, s_res_data} !== {1'b1, e.id, e.data}) $display("FAIL t6_result%0d: got ok=%b id=%b data=%h want ok=1 id=%b data=%h", k, ok, s_res_id, s_res_data, e.id, e.data); else passed++;
    end
    s_r0_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0; res_ready = 1'b0;
    r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
    s_r0_valid = 1'b0; s_r1_valid = 1'b0; s_res_ready = 1'b0;
    s_r0_a = '0; s_r0_b = '0; s_r1_a = '0; s_r1_b = '0;
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_reset_mid();
    test_zero();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
